ssd_scan_ctrl: RTL and testbench



---
 rtl/ssd_scan_ctrl_pkg.sv | 36 +++
 rtl/ssd_scan_ctrl_hex7seg.sv | 11 +
 rtl/ssd_scan_ctrl.sv | 117 +++++++++++
 tb/tb_ssd_scan_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ssd_scan_ctrl_pkg.sv
// Shared constants for the seven-segment scan controller: blanking patterns
// and the active-low gfedcba segment set for hex digits 0..F.
package ssd_scan_ctrl_pkg;

  localparam logic [6:0] SSD_BLANK = 7'b1111111;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  // Element [n] holds the pattern for hex value n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  typedef enum logic {
    PH_GUARD = 1'b0,
    PH_DRIVE = 1'b1
  } phase_e;

endpackage

// File: rtl/ssd_scan_ctrl_hex7seg.sv
// Combinational hex to seven-segment decoder (active-low gfedcba).
module ssd_scan_ctrl_hex7seg
  import ssd_scan_ctrl_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed common-anode seven-segment scanner with per-slot anti-ghosting
// guard and frame-boundary commit of new display words.
//
// phase    | meaning
// PH_GUARD | tick < GUARD: all anodes off, segments blank
// PH_DRIVE | tick >= GUARD: anode of digit dig on unless blanked
module ssd_scan_ctrl
  import ssd_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] in_value,
  input  logic [NUM_DIGITS-1:0]   in_blank,
  input  logic                    in_load,
  output logic                    out_ready,
  output logic [6:0]              out_ssd,
  output logic [NUM_DIGITS-1:0]   out_an
);

  localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [TW-1:0]         TICK_LAST  = TW'(REFRESH_DIV - 1);
  localparam logic [TW-1:0]         TICK_GUARD = TW'(GUARD);
  localparam logic [DW-1:0]         DIG_LAST   = DW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = AN_OFF[NUM_DIGITS-1:0];

  logic [TW-1:0]           tick;
  logic [DW-1:0]           dig;
  logic [4*NUM_DIGITS-1:0] disp_val;
  logic [NUM_DIGITS-1:0]   disp_blank;
  logic [4*NUM_DIGITS-1:0] pend_val;
  logic [NUM_DIGITS-1:0]   pend_blank;
  logic                    pending;

  logic                    slot_end;
  logic                    frame_end;
  logic                    load_fire;
  phase_e                  phase;
  logic [3:0]              cur_nib;
  logic                    cur_blank;
  logic [6:0]              cur_seg;
  logic [NUM_DIGITS-1:0]   an_sel;
  logic [NUM_DIGITS-1:0]   an_next;
  logic [6:0]              ssd_next;

  assign slot_end  = (tick == TICK_LAST);
  assign frame_end = slot_end && (dig == DIG_LAST);
  // The staged copy is free exactly when nothing is waiting to commit.
  assign out_ready = ~pending;
  assign load_fire = in_load && out_ready;
  assign phase     = (tick < TICK_GUARD) ? PH_GUARD : PH_DRIVE;
  assign cur_nib   = disp_val[4*int'(dig) +: 4];
  assign cur_blank = disp_blank[dig];
  assign an_sel    = ~(NUM_DIGITS'(1) << dig);

  ssd_scan_ctrl_hex7seg u_hex7seg (
    .hex (cur_nib),
    .seg (cur_seg)
  );

  always_comb begin
    an_next  = AN_ALL_OFF;
    ssd_next = SSD_BLANK;
    if (phase == PH_DRIVE && !cur_blank) begin
      an_next  = an_sel;
      ssd_next = cur_seg;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick <= '0;
      dig  <= '0;
    end else if (slot_end) begin
      tick <= '0;
      dig  <= (dig == DIG_LAST) ? '0 : dig + DW'(1);
    end else begin
      tick <= tick + TW'(1);
    end
  end

  // Commit only at a frame boundary so a frame never mixes old and new data;
  // a load landing on a boundary sees pending=0 and waits one more frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      disp_val   <= '0;
      disp_blank <= '1;
      pend_val   <= '0;
      pend_blank <= '1;
      pending    <= 1'b0;
    end else if (frame_end && pending) begin
      disp_val   <= pend_val;
      disp_blank <= pend_blank;
      pending    <= 1'b0;
    end else if (load_fire) begin
      pend_val   <= in_value;
      pend_blank <= in_blank;
      pending    <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_an  <= AN_ALL_OFF;
      out_ssd <= SSD_BLANK;
    end else begin
      out_an  <= an_next;
      out_ssd <= ssd_next;
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Scoreboard bench for ssd_scan_ctrl: a cycle-count based reference model
// queues expected outputs, a monitor pops and compares after each edge.
module tb_ssd_scan_ctrl;

  localparam int ND    = 4;
  localparam int RD    = 8;
  localparam int GD    = 2;
  localparam int FRAME = RD * ND;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] in_value = '0;
  logic [3:0]  in_blank = '0;
  logic        in_load = 1'b0;
  logic        out_ready;
  logic [6:0]  out_ssd;
  logic [3:0]  out_an;

  ssd_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .GUARD       (GD)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_value  (in_value),
    .in_blank  (in_blank),
    .in_load   (in_load),
    .out_ready (out_ready),
    .out_ssd   (out_ssd),
    .out_an    (out_an)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         k;
    logic [3:0] an;
    logic [6:0] ssd;
    logic       rdy;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;

  logic [6:0] seg_ref [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference: position in the scan is derived purely from edges since reset.
  int          k;
  logic [15:0] m_shown_val, m_next_val;
  logic [3:0]  m_shown_blank, m_next_blank;
  bit          m_waiting;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    k             = 0;
    m_shown_val   = '0;
    m_shown_blank = 4'hF;
    m_next_val    = '0;
    m_next_blank  = 4'hF;
    m_waiting     = 1'b0;
  endtask

  // Drive inputs for the coming edge, queue what that edge must produce.
  task automatic step(input bit ld, input logic [15:0] v, input logic [3:0] b);
    exp_t e;
    int   slot_pos, digit;
    bit   accepting;
    in_load  = ld;
    in_value = v;
    in_blank = b;
    slot_pos = k % RD;
    digit    = (k / RD) % ND;
    e.k      = k;
    if (slot_pos < GD || m_shown_blank[digit]) begin
      e.an  = 4'hF;
      e.ssd = 7'h7F;
    end else begin
      e.an  = ~(4'b0001 << digit);
      e.ssd = seg_ref[int'((m_shown_val >> (4 * digit)) & 16'hF)];
    end
    accepting = !m_waiting;
    if ((k % FRAME) == FRAME - 1 && m_waiting) begin
      m_shown_val   = m_next_val;
      m_shown_blank = m_next_blank;
      m_waiting     = 1'b0;
    end
    if (ld && accepting) begin
      m_next_val   = v;
      m_next_blank = b;
      m_waiting    = 1'b1;
    end
    e.rdy = !m_waiting;
    q.push_back(e);
    k++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0);
  endtask

  task automatic wait_phase(input int target);
    for (int i = 0; i < FRAME && (k % FRAME) != target; i++) step(1'b0, 16'h0, 4'h0);
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (q.size() == 0) begin
        check("queue_underrun", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check($sformatf("out_an@%0d", e.k), out_an, e.an);
        check($sformatf("out_ssd@%0d", e.k), out_ssd, e.ssd);
        check($sformatf("out_ready@%0d", e.k), out_ready, e.rdy);
      end
      check("an_at_most_one", ($countones(~out_an) <= 1), 1'b1);
      if (out_an == 4'hF) check("dark_segments", out_ssd, 7'h7F);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("reset_an", out_an, 4'hF);
    check("reset_ssd", out_ssd, 7'h7F);
    check("reset_ready", out_ready, 1'b1);
    reset_n = 1'b1;
    model_reset();
    q.delete();
    mon_en = 1'b1;
    check("release_an", out_an, 4'hF);

    // Load at tick 3 of digit 1.
    wait_phase(RD + 3);
    step(1'b1, 16'h3210, 4'h0);
    idle(2 * FRAME + 6);

    // Blank mask hides digit 2.
    step(1'b1, 16'hFEDC, 4'b0100);
    idle(2 * FRAME + 6);

    // Second load while busy must be dropped.
    step(1'b1, 16'h1234, 4'h0);
    step(1'b1, 16'hAAAA, 4'h0);
    idle(2 * FRAME + 6);

    // Load on the frame-boundary cycle waits a full extra frame.
    wait_phase(FRAME - 1);
    step(1'b1, 16'h5678, 4'h0);
    idle(3 * FRAME);

    // Asynchronous reset mid-slot with a load still staged.
    step(1'b1, 16'h9ABC, 4'h0);
    idle(5);
    mon_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_an", out_an, 4'hF);
    check("async_reset_ssd", out_ssd, 7'h7F);
    check("async_reset_ready", out_ready, 1'b1);
    q.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    mon_en = 1'b1;
    check("rerelease_an", out_an, 4'hF);
    idle(2 * FRAME + 3);

    // Random loads, values and blank masks.
    for (int i = 0; i < 1000; i++) begin
      bit          ld;
      logic [15:0] v;
      logic [3:0]  b;
      ld = ($urandom_range(0, 11) == 0);
      v  = 16'($urandom);
      b  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      step(ld, v, b);
    end

    check("queue_drained", q.size(), 0);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
